unum4_pack_pipe: RTL

Multi-lane, fully pipelined unum4 packer with valid/ready flow control. Each lane takes a signed exponent and a normalised two's-complement mantissa and produces one variable-field unum4 word. Beyond a single-lane pack it adds round-to-nearest-even, saturation/underflow/invalid flags, a reserved zero encoding and backpressure. It sits between the unum4 arithmetic cores and the result writeback.

---
 rtl/unum4_pack_pipe.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/unum4_pack_pipe.sv
// Multi-lane, three-stage unum4 packer: exponent sizing, RNE rounding, special
// encodings and ovf/unf/inv flags behind one shared valid/ready handshake.
module unum4_pack_pipe #(
   parameter int DATA_W    = 32,
   parameter int MAN_MAX_W = 29,
   parameter int EXP_SZ_W  = 4,
   parameter int EXP_MAX_W = 16,
   parameter int LANES     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*EXP_MAX_W-1:0] in_exp,
   input  logic [LANES*MAN_MAX_W-1:0] in_mant,
   input  logic                       rnd_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*DATA_W-1:0]    out_data,
   output logic [LANES*3-1:0]         out_flags
);
   localparam int ESMAX  = 2**EXP_SZ_W - 2;
   localparam int FW     = MAN_MAX_W - 1;
   localparam int ES_W   = $clog2(EXP_MAX_W + 1);
   localparam int D0     = FW - (DATA_W - EXP_SZ_W);
   localparam int DROP_W = $clog2(FW + 1);
   localparam int MW_OVF = DATA_W - EXP_SZ_W - ESMAX;

   localparam logic [DATA_W-1:0] SPECIAL_WORD = DATA_W'((1 << EXP_SZ_W) - 1);
   // Saturated word: es = ESMAX, largest positive exponent, field filled per sign.
   localparam logic [DATA_W-1:0] OVF_BASE =
      (((DATA_W'(1) << (ESMAX - 1)) - DATA_W'(1)) << (DATA_W - ESMAX)) | DATA_W'(ESMAX);
   localparam logic [DATA_W-1:0] OVF_FIELD =
      ((DATA_W'(1) << MW_OVF) - DATA_W'(1)) << EXP_SZ_W;

   typedef enum logic [2:0] {
      K_NORM,
      K_ZERO,
      K_INV,
      K_OVF,
      K_UNF
   } kind_t;

   logic en;
   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic v3_q, v3_d;
   logic rnd1_q, rnd1_d;

   // One global enable: every stage stalls together, bubbles are kept.
   assign en        = !v3_q || out_ready;
   assign in_ready  = en;
   assign out_valid = v3_q;

   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      rnd1_d = rnd1_q;
      if (en) begin
         v1_d   = in_valid;
         v2_d   = v1_q;
         v3_d   = v2_q;
         rnd1_d = rnd_mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         rnd1_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         rnd1_q <= rnd1_d;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [EXP_MAX_W-1:0] exp_in;
      logic [MAN_MAX_W-1:0] mant_in;
      logic [ES_W-1:0]      es_calc;
      kind_t                kind_calc;

      logic [EXP_MAX_W-1:0] exp1_q, exp1_d;
      logic [MAN_MAX_W-1:0] mant1_q, mant1_d;
      logic [ES_W-1:0]      es1_q, es1_d;
      kind_t                kind1_q, kind1_d;

      logic [DROP_W-1:0]    drop;
      logic [FW-1:0]        mant_low;
      logic [FW-1:0]        inc_bit;
      logic [FW-1:0]        lsb_mask;
      logic [FW-1:0]        guard_mask;
      logic [FW-1:0]        trunc;
      logic [FW-1:0]        sum;
      logic [FW-1:0]        rounded;
      logic                 guard;
      logic                 sticky;
      logic                 odd;
      logic                 do_inc;
      logic [DATA_W-1:0]    exp_mask;
      logic [DATA_W-1:0]    word_norm;

      logic [DATA_W-1:0]    data2_q, data2_d;
      logic [2:0]           flags2_q, flags2_d;
      logic [DATA_W-1:0]    data3_q, data3_d;
      logic [2:0]           flags3_q, flags3_d;

      assign exp_in  = in_exp[gi*EXP_MAX_W +: EXP_MAX_W];
      assign mant_in = in_mant[gi*MAN_MAX_W +: MAN_MAX_W];

      // es = 2 + index of the highest bit differing from the sign; -1 needs 1 bit.
      always_comb begin
         es_calc = (exp_in == '0) ? '0 : ES_W'(1);
         for (int i = 0; i < EXP_MAX_W - 1; i++) begin
            if (exp_in[i] != exp_in[EXP_MAX_W-1]) begin
               es_calc = ES_W'(i + 2);
            end
         end
      end

      always_comb begin
         kind_calc = K_NORM;
         if (mant_in == '0) begin
            kind_calc = K_ZERO;
         end else if (mant_in[MAN_MAX_W-1] == mant_in[MAN_MAX_W-2]) begin
            kind_calc = K_INV;
         end else if (es_calc > ES_W'(ESMAX)) begin
            kind_calc = exp_in[EXP_MAX_W-1] ? K_UNF : K_OVF;
         end
      end

      always_comb begin
         exp1_d  = exp1_q;
         mant1_d = mant1_q;
         es1_d   = es1_q;
         kind1_d = kind1_q;
         if (en && in_valid) begin
            exp1_d  = exp_in;
            mant1_d = mant_in;
            es1_d   = es_calc;
            kind1_d = kind_calc;
         end
      end

      // Rounding is done left-aligned: the field MSB sits at mant_low[FW-1].
      always_comb begin
         drop       = DROP_W'(es1_q) + DROP_W'(D0);
         mant_low   = mant1_q[FW-1:0];
         inc_bit    = FW'(1) << drop;
         lsb_mask   = inc_bit - FW'(1);
         guard_mask = lsb_mask ^ (lsb_mask >> 1);
         trunc      = mant_low & ~lsb_mask;
         guard      = |(mant_low & guard_mask);
         sticky     = |(mant_low & (lsb_mask >> 1));
         odd        = |(mant_low & inc_bit);
         do_inc     = rnd1_q && guard && (sticky || odd);
         sum        = trunc + inc_bit;
         rounded    = trunc;
         if (do_inc && (sum[FW-1] == mant_low[FW-1])) begin
            rounded = sum;
         end
         exp_mask  = (DATA_W'(1) << es1_q) - DATA_W'(1);
         word_norm = ((DATA_W'(exp1_q) & exp_mask) << (DATA_W - int'(es1_q)))
                   | (DATA_W'(rounded >> drop) << EXP_SZ_W)
                   | DATA_W'(es1_q);

         data2_d  = data2_q;
         flags2_d = flags2_q;
         if (en && v1_q) begin
            case (kind1_q)
               K_ZERO: begin
                  data2_d  = SPECIAL_WORD;
                  flags2_d = 3'b000;
               end
               K_INV: begin
                  data2_d  = SPECIAL_WORD;
                  flags2_d = 3'b100;
               end
               K_OVF: begin
                  data2_d  = OVF_BASE | (mant1_q[MAN_MAX_W-1] ? '0 : OVF_FIELD);
                  flags2_d = 3'b001;
               end
               K_UNF: begin
                  data2_d  = SPECIAL_WORD;
                  flags2_d = 3'b010;
               end
               default: begin
                  data2_d  = word_norm;
                  flags2_d = 3'b000;
               end
            endcase
         end
      end

      always_comb begin
         data3_d  = data3_q;
         flags3_d = flags3_q;
         if (en && v2_q) begin
            data3_d  = data2_q;
            flags3_d = flags2_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            exp1_q   <= '0;
            mant1_q  <= '0;
            es1_q    <= '0;
            kind1_q  <= K_NORM;
            data2_q  <= '0;
            flags2_q <= '0;
            data3_q  <= '0;
            flags3_q <= '0;
         end else begin
            exp1_q   <= exp1_d;
            mant1_q  <= mant1_d;
            es1_q    <= es1_d;
            kind1_q  <= kind1_d;
            data2_q  <= data2_d;
            flags2_q <= flags2_d;
            data3_q  <= data3_d;
            flags3_q <= flags3_d;
         end
      end

      assign out_data[gi*DATA_W +: DATA_W] = data3_q;
      assign out_flags[gi*3 +: 3]          = flags3_q;
   end

endmodule
